// File: rtl/timer_pkg.sv
// Shared constants for the shot clock timer: FSM state codes, default presets
// and a small width helper used for the preset select port.
package timer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam int DEF_CNT_W    = 5;
    localparam int DEF_N_PRESET = 2;

    // Entry 0 sits in the low bits: entry 0 = 24, entry 1 = 14.
    localparam logic [DEF_N_PRESET*DEF_CNT_W-1:0] DEF_PRESETS = {5'd14, 5'd24};

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buzz_timer.sv
// Buzzer duration timer: raises the buzzer on start and drops it on the edge
// that samples the BUZZ_LEN-th tick afterwards.
module buzz_timer #(
    parameter int BUZZ_LEN = 3,
    localparam int BW      = $clog2(BUZZ_LEN + 1)
) (
    input  logic clk,
    input  logic clear,
    input  logic start,
    input  logic abort,
    input  logic tick,
    output logic buzzer
);

    logic          r_buzz;
    logic [BW-1:0] r_ticks;

    // The tick coinciding with start is deliberately not counted.
    always_ff @(posedge clk) begin
        if (clear || abort) begin
            r_buzz  <= 1'b0;
            r_ticks <= '0;
        end else if (start) begin
            r_buzz  <= 1'b1;
            r_ticks <= '0;
        end else if (r_buzz && tick) begin
            if (r_ticks == BW'(BUZZ_LEN - 1)) begin
                r_buzz  <= 1'b0;
                r_ticks <= '0;
            end else begin
                r_ticks <= r_ticks + BW'(1);
            end
        end
    end

    assign buzzer = r_buzz;

endmodule

// File: rtl/shot_clock_timer.sv
// Shot clock timer: loadable up/down counter with run/pause control, one-cycle
// expiry pulse, optional auto-reload and a buzzer held for BUZZ_LEN ticks.
module shot_clock_timer
    import timer_pkg::*;
#(
    parameter int                          CNT_W       = DEF_CNT_W,
    parameter int                          N_PRESET    = DEF_N_PRESET,
    parameter logic [N_PRESET*CNT_W-1:0]   PRESETS     = DEF_PRESETS,
    parameter int                          BUZZ_LEN    = 3,
    parameter bit                          AUTO_RELOAD = 1'b0,
    localparam int                         SEL_W       = sel_width(N_PRESET)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             tick,
    input  logic             load,
    input  logic [SEL_W-1:0] preset_sel,
    input  logic             run,
    input  logic             dir,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic             expired,
    output logic             buzzer
);

    if (BUZZ_LEN < 1) begin : g_bad_buzz_len
        $fatal(1, "shot_clock_timer: BUZZ_LEN must be at least 1");
    end

    for (genvar gi = 0; gi < N_PRESET; gi++) begin : g_preset_check
        if (longint'(PRESETS[gi*CNT_W +: CNT_W]) > (longint'(1) << CNT_W) - 1) begin : g_bad_preset
            $fatal(1, "shot_clock_timer: preset entry exceeds counter range");
        end
    end

    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state;
    logic             r_expired;

    logic [CNT_W-1:0] w_preset;
    logic [CNT_W-1:0] w_start;
    logic [CNT_W-1:0] w_term;
    logic             w_at_or_past;
    logic [CNT_W-1:0] w_stepped;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [1:0]       w_st_nx;
    logic             w_expire_now;

    // Out-of-range selects (non power-of-two N_PRESET) fall back to entry 0.
    always_comb begin
        w_preset = PRESETS[0 +: CNT_W];
        if (int'(preset_sel) < N_PRESET) begin
            w_preset = PRESETS[int'(preset_sel)*CNT_W +: CNT_W];
        end
    end

    assign w_start = dir ? '0 : w_preset;
    assign w_term  = dir ? w_preset : '0;

    // A count already at or beyond the terminal snaps to it, so it never wraps.
    assign w_at_or_past = dir ? (r_count >= w_term) : (r_count <= w_term);
    assign w_stepped    = w_at_or_past ? w_term
                        : (dir ? r_count + CNT_W'(1) : r_count - CNT_W'(1));

    always_comb begin
        w_cnt_nx     = r_count;
        w_st_nx      = r_state;
        w_expire_now = 1'b0;
        if (load) begin
            w_cnt_nx = w_start;
            w_st_nx  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSED: begin
                    if (run) begin
                        if (r_count == w_term) begin
                            w_st_nx      = ST_EXPIRED;
                            w_expire_now = 1'b1;
                        end else begin
                            w_st_nx = ST_RUNNING;
                        end
                    end
                end
                ST_RUNNING: begin
                    if (!run) begin
                        w_st_nx = ST_PAUSED;
                    end else if (tick) begin
                        w_cnt_nx = w_stepped;
                        if (w_stepped == w_term) begin
                            w_st_nx      = ST_EXPIRED;
                            w_expire_now = 1'b1;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (AUTO_RELOAD) begin
                        w_cnt_nx = w_start;
                        w_st_nx  = run ? ST_RUNNING : ST_PAUSED;
                    end
                end
                default: w_st_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count   <= '0;
            r_state   <= ST_IDLE;
            r_expired <= 1'b0;
        end else begin
            r_count   <= w_cnt_nx;
            r_state   <= w_st_nx;
            r_expired <= w_expire_now;
        end
    end

    buzz_timer #(
        .BUZZ_LEN (BUZZ_LEN)
    ) u_buzz (
        .clk    (clk),
        .clear  (clear),
        .start  (w_expire_now),
        .abort  (load),
        .tick   (tick),
        .buzzer (buzzer)
    );

    assign count   = r_count;
    assign state   = r_state;
    assign expired = r_expired;

endmodule

// File: tb/tb_shot_clock_timer.sv
// Bench for shot_clock_timer: three configurations share one random/directed
// input stream and are checked every cycle against a behavioural model.
module tb_shot_clock_timer;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       load = 1'b0;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic       tick = 1'b0;
    logic [0:0] psel = 1'b0;

    logic [4:0] dut_count [NI];
    logic [1:0] dut_state [NI];
    logic       dut_exp   [NI];
    logic       dut_buzz  [NI];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model configuration, one entry per instance.
    int pre   [NI][2] = '{'{24, 14}, '{5, 3}, '{0, 9}};
    bit autor [NI]    = '{1'b0, 1'b1, 1'b0};
    int blen  [NI]    = '{3, 3, 1};

    // Model state: mode 0 idle, 1 running, 2 paused, 3 expired.
    int m_cnt  [NI];
    int m_mode [NI];
    int m_exp  [NI];
    int m_left [NI];

    always #5 clk = ~clk;

    shot_clock_timer u_dut0 (
        .clk(clk), .clear(clear), .tick(tick), .load(load), .preset_sel(psel),
        .run(run), .dir(dir), .count(dut_count[0]), .state(dut_state[0]),
        .expired(dut_exp[0]), .buzzer(dut_buzz[0])
    );

    shot_clock_timer #(
        .CNT_W(5), .N_PRESET(2), .PRESETS({5'd3, 5'd5}), .BUZZ_LEN(3), .AUTO_RELOAD(1'b1)
    ) u_dut1 (
        .clk(clk), .clear(clear), .tick(tick), .load(load), .preset_sel(psel),
        .run(run), .dir(dir), .count(dut_count[1]), .state(dut_state[1]),
        .expired(dut_exp[1]), .buzzer(dut_buzz[1])
    );

    shot_clock_timer #(
        .CNT_W(5), .N_PRESET(2), .PRESETS({5'd9, 5'd0}), .BUZZ_LEN(1), .AUTO_RELOAD(1'b0)
    ) u_dut2 (
        .clk(clk), .clear(clear), .tick(tick), .load(load), .preset_sel(psel),
        .run(run), .dir(dir), .count(dut_count[2]), .state(dut_state[2]),
        .expired(dut_exp[2]), .buzzer(dut_buzz[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: one call per clock edge per instance.
    task automatic model_step(input int k);
        int p, s, t, step;
        bit fire;
        p    = pre[k][psel];
        s    = dir ? 0 : p;
        t    = dir ? p : 0;
        fire = 1'b0;
        if (clear) begin
            m_cnt[k] = 0; m_mode[k] = 0; m_left[k] = 0;
        end else if (load) begin
            m_cnt[k] = s; m_mode[k] = 0; m_left[k] = 0;
        end else begin
            if (m_mode[k] == 0 || m_mode[k] == 2) begin
                if (run) begin
                    if (m_cnt[k] == t) begin m_mode[k] = 3; fire = 1'b1; end
                    else m_mode[k] = 1;
                end
            end else if (m_mode[k] == 1) begin
                if (!run) m_mode[k] = 2;
                else if (tick) begin
                    step = dir ? 1 : -1;
                    if ((t - m_cnt[k]) * step > 0) m_cnt[k] = m_cnt[k] + step;
                    else m_cnt[k] = t;
                    if (m_cnt[k] == t) begin m_mode[k] = 3; fire = 1'b1; end
                end
            end else if (autor[k]) begin
                m_cnt[k]  = s;
                m_mode[k] = run ? 1 : 2;
            end
            if (fire) m_left[k] = blen[k];
            else if (tick && m_left[k] > 0) m_left[k] = m_left[k] - 1;
        end
        m_exp[k] = fire ? 1 : 0;
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) model_step(k);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("model_count%0d", k), int'(dut_count[k]), m_cnt[k]);
                chk($sformatf("model_state%0d", k), int'(dut_state[k]), m_mode[k]);
                chk($sformatf("model_expired%0d", k), int'(dut_exp[k]), m_exp[k]);
                chk($sformatf("model_buzzer%0d", k), int'(dut_buzz[k]), (m_left[k] > 0) ? 1 : 0);
            end
        end
    end

    // Drive one cycle of control inputs, return just after the following negedge.
    task automatic cyc(input bit cl, input bit ld, input bit rn, input bit tk);
        clear = cl; load = ld; run = rn; tick = tk;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        @(negedge clk);
        cyc(1, 0, 0, 0);
        chk_en = 1'b1;
        chk("reset_count", int'(dut_count[0]), 0);
        chk("reset_state", int'(dut_state[0]), 0);
        chk("reset_buzzer", int'(dut_buzz[0]), 0);

        // Count down from 24; instance 2 (preset 0) expires as soon as it runs.
        dir = 1'b0; psel = 1'b0;
        cyc(0, 1, 0, 0);
        chk("load24", int'(dut_count[0]), 24);
        cyc(0, 0, 1, 0);
        chk("run_entry_state", int'(dut_state[0]), 1);
        chk("zero_preset_expired", int'(dut_exp[2]), 1);
        chk("zero_preset_state", int'(dut_state[2]), 3);
        for (int i = 0; i < 23; i++) cyc(0, 0, 1, 1);
        chk("down_count1", int'(dut_count[0]), 1);
        chk("zero_preset_single_pulse", int'(dut_exp[2]), 0);
        cyc(0, 0, 1, 1);
        chk("down_expire_count", int'(dut_count[0]), 0);
        chk("down_expire_state", int'(dut_state[0]), 3);
        chk("down_expire_pulse", int'(dut_exp[0]), 1);
        chk("down_expire_buzz", int'(dut_buzz[0]), 1);
        cyc(0, 0, 1, 0);
        chk("pulse_one_cycle", int'(dut_exp[0]), 0);
        n = 0;
        for (int i = 0; i < 10 && dut_buzz[0]; i++) begin
            cyc(0, 0, 1, 1);
            n++;
        end
        chk("buzz_ticks", n, 3);

        // Count up to 14, then confirm it holds.
        dir = 1'b1; psel = 1'b1;
        cyc(0, 1, 0, 0);
        chk("up_load", int'(dut_count[0]), 0);
        cyc(0, 0, 1, 1);
        chk("up_entry_no_count", int'(dut_count[0]), 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 1, 1);
        chk("up_expire_count", int'(dut_count[0]), 14);
        chk("up_expire_pulse", int'(dut_exp[0]), 1);
        cyc(0, 0, 1, 1);
        chk("up_hold", int'(dut_count[0]), 14);

        // Pause at 10 for five ticks, resume.
        dir = 1'b0; psel = 1'b0;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 1, 1);
        chk("pause_at10", int'(dut_count[0]), 10);
        cyc(0, 0, 0, 1);
        chk("paused_state", int'(dut_state[0]), 2);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        chk("paused_hold", int'(dut_count[0]), 10);
        cyc(0, 0, 1, 1);
        chk("resume_hold", int'(dut_count[0]), 10);
        chk("resume_state", int'(dut_state[0]), 1);
        cyc(0, 0, 1, 1);
        chk("resume_step", int'(dut_count[0]), 9);

        // Clear beats load and tick while running at 7.
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        chk("at7", int'(dut_count[0]), 7);
        cyc(1, 1, 1, 1);
        chk("clear_pri_count", int'(dut_count[0]), 0);
        chk("clear_pri_state", int'(dut_state[0]), 0);
        chk("clear_pri_buzz", int'(dut_buzz[0]), 0);

        // Auto-reload instance: 5..0, then back to 5 and running.
        cyc(0, 1, 0, 0);
        chk("ar_load", int'(dut_count[1]), 5);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1);
        chk("ar_expire_count", int'(dut_count[1]), 0);
        chk("ar_expire_pulse", int'(dut_exp[1]), 1);
        cyc(0, 0, 1, 0);
        chk("ar_reload_count", int'(dut_count[1]), 5);
        chk("ar_reload_state", int'(dut_state[1]), 1);
        chk("ar_buzz_on", int'(dut_buzz[1]), 1);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) dir = ~dir;
            if ($urandom_range(0, 15) == 0) psel = 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
